// File: rtl/wormhole_arbiter_5_if.sv
// Allocator-side bundle for one router output port: requests, tails and flits in,
// one-hot select, muxed flit and pop pulses out.
interface wormhole_arbiter_5_if #(
  parameter int DATA_WIDTH = 4
);
  logic [4:0]              req_i;
  logic [4:0]              tail_i;
  logic [5*DATA_WIDTH-1:0] flit_i;
  logic                    out_ready_i;
  logic [4:0]              sel_o;
  logic                    out_valid_o;
  logic [DATA_WIDTH-1:0]   out_flit_o;
  logic [4:0]              ack_o;

  modport slave (
    input  req_i, tail_i, flit_i, out_ready_i,
    output sel_o, out_valid_o, out_flit_o, ack_o
  );

  modport master (
    output req_i, tail_i, flit_i, out_ready_i,
    input  sel_o, out_valid_o, out_flit_o, ack_o
  );
endinterface

// File: rtl/wormhole_arbiter_5.sv
// Per-output wormhole switch allocator: round-robin over 5 inputs, packet-locked
// grant released on tail transfer with same-cycle re-arbitration.
module wormhole_arbiter_5 #(
  parameter int DATA_WIDTH = 4,
  parameter int PTR_INIT   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  wormhole_arbiter_5_if.slave  bus
);

  typedef enum logic {IDLE, LOCKED} state_e;

  localparam logic [2:0] PTR_RST = 3'(PTR_INIT);

  state_e     state_q;
  logic [4:0] sel_q;
  logic [2:0] ptr_q;

  logic [4:0]            hit;
  logic                  xfer;
  logic                  tail_xfer;
  logic [2:0]            g_idx;
  logic [2:0]            ptr_d;
  logic [4:0]            others;
  logic [4:0]            gnt_idle;
  logic [4:0]            gnt_tail;
  logic [DATA_WIDTH-1:0] flit_mux;

  // First set bit of req scanning upward from ptr, wrapping 4 -> 0.
  function automatic logic [4:0] rr_pick(input logic [4:0] req, input logic [2:0] ptr);
    logic [4:0] gnt;
    logic       found;
    int         idx;
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idx = int'(ptr) + i;
      if (idx >= 5) idx = idx - 5;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

  function automatic logic [2:0] onehot_idx(input logic [4:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 5; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  always_comb begin
    hit       = sel_q & bus.req_i;
    xfer      = (|hit) & bus.out_ready_i;
    tail_xfer = xfer & (|(sel_q & bus.tail_i));
    g_idx     = onehot_idx(sel_q);
    ptr_d     = (g_idx == 3'd4) ? 3'd0 : g_idx + 3'd1;
    others    = bus.req_i & ~sel_q;
    gnt_idle  = rr_pick(bus.req_i, ptr_q);
    gnt_tail  = rr_pick(others, ptr_d);
    flit_mux  = '0;
    for (int k = 0; k < 5; k++) begin
      if (sel_q[k]) flit_mux = flit_mux | bus.flit_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign bus.sel_o       = sel_q;
  assign bus.out_valid_o = |hit;
  assign bus.out_flit_o  = flit_mux;
  assign bus.ack_o       = xfer ? hit : 5'b0;

  // The pointer only advances past a finished packet, never on grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 5'b0;
      ptr_q   <= PTR_RST;
    end else begin
      case (state_q)
        IDLE: begin
          if (|bus.req_i) begin
            sel_q   <= gnt_idle;
            state_q <= LOCKED;
          end
        end
        LOCKED: begin
          if (tail_xfer) begin
            ptr_q   <= ptr_d;
            sel_q   <= gnt_tail;
            state_q <= (|others) ? LOCKED : IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          sel_q   <= 5'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wormhole_arbiter_5.sv
// Directed bench for wormhole_arbiter_5: lock, release, fairness, back-pressure,
// starvation and mid-packet reset, with hand-computed expectations.
module tb_wormhole_arbiter_5;
  localparam int W = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  bit   armed;

  wormhole_arbiter_5_if #(.DATA_WIDTH(W)) bus ();

  wormhole_arbiter_5 #(.DATA_WIDTH(W), .PTR_INIT(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed && !rst) chk("sel_onehot0", 32'($onehot0(bus.sel_o)), 32'd1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] req, input logic [4:0] tail, input logic rdy);
    bus.req_i       = req;
    bus.tail_i      = tail;
    bus.out_ready_i = rdy;
  endtask

  task automatic set_flit(input int k, input logic [W-1:0] v);
    bus.flit_i[k*W +: W] = v;
  endtask

  task automatic expect_out(input string tag, input logic [4:0] sel, input logic vld,
                            input logic [W-1:0] flit, input logic [4:0] ack);
    #4;
    chk({tag, ".sel"},   32'(bus.sel_o),       32'(sel));
    chk({tag, ".valid"}, 32'(bus.out_valid_o), 32'(vld));
    chk({tag, ".flit"},  32'(bus.out_flit_o),  32'(flit));
    chk({tag, ".ack"},   32'(bus.ack_o),       32'(ack));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(5'b0, 5'b0, 1'b0);
    tick();
    tick();
    expect_out("reset", 5'b0, 1'b0, 4'h0, 5'b0);
    tick();
    rst   = 1'b0;
    armed = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    armed    = 1'b0;
    rst      = 1'b1;
    bus.flit_i = '0;
    drive(5'b0, 5'b0, 1'b0);
    set_flit(0, 4'hC);
    set_flit(1, 4'hB);
    set_flit(2, 4'hA);
    set_flit(3, 4'h9);
    set_flit(4, 4'h8);

    // Single-flit packet on input 2, then pointer must sit at 3.
    do_reset();
    drive(5'b00100, 5'b00100, 1'b1);
    expect_out("t1.c0", 5'b0, 1'b0, 4'h0, 5'b0);
    tick();
    expect_out("t1.c1", 5'b00100, 1'b1, 4'hA, 5'b00100);
    tick();
    drive(5'b11111, 5'b11111, 1'b1);
    expect_out("t1.c2", 5'b0, 1'b0, 4'h0, 5'b0);
    tick();
    expect_out("t1.ptr3", 5'b01000, 1'b1, 4'h9, 5'b01000);
    tick();
    drive(5'b10000, 5'b10000, 1'b1);
    expect_out("t1.next4", 5'b10000, 1'b1, 4'h8, 5'b10000);
    tick();
    drive(5'b0, 5'b0, 1'b1);
    expect_out("t1.idle", 5'b0, 1'b0, 4'h0, 5'b0);

    // 3-flit packet on input 1 while input 3 waits; no bubble on handover.
    do_reset();
    drive(5'b01010, 5'b00000, 1'b1);
    set_flit(1, 4'h1);
    tick();
    expect_out("t2.f1", 5'b00010, 1'b1, 4'h1, 5'b00010);
    tick();
    set_flit(1, 4'h2);
    expect_out("t2.f2", 5'b00010, 1'b1, 4'h2, 5'b00010);
    tick();
    set_flit(1, 4'h3);
    drive(5'b01010, 5'b00010, 1'b1);
    expect_out("t2.f3", 5'b00010, 1'b1, 4'h3, 5'b00010);
    tick();
    drive(5'b01000, 5'b01000, 1'b1);
    expect_out("t2.hand", 5'b01000, 1'b1, 4'h9, 5'b01000);
    tick();
    drive(5'b0, 5'b0, 1'b1);
    expect_out("t2.idle", 5'b0, 1'b0, 4'h0, 5'b0);
    set_flit(1, 4'hB);

    // All inputs send single-flit packets: strict 0,1,2,3,4,0 rotation.
    do_reset();
    drive(5'b11111, 5'b11111, 1'b1);
    expect_out("t3.c0", 5'b0, 1'b0, 4'h0, 5'b0);
    for (int k = 0; k < 6; k++) begin
      logic [4:0]   oh;
      logic [3:0]   fl;
      tick();
      oh = 5'b00001 << (k % 5);
      fl = 4'hC - 4'(k % 5);
      expect_out($sformatf("t3.g%0d", k), oh, 1'b1, fl, oh);
    end

    // Back-pressure on a packet locked to input 4.
    do_reset();
    drive(5'b10000, 5'b00000, 1'b0);
    tick();
    expect_out("t4.bp1", 5'b10000, 1'b1, 4'h8, 5'b0);
    tick();
    drive(5'b11111, 5'b01111, 1'b0);
    expect_out("t4.bp2", 5'b10000, 1'b1, 4'h8, 5'b0);
    tick();
    expect_out("t4.bp3", 5'b10000, 1'b1, 4'h8, 5'b0);
    tick();
    drive(5'b10000, 5'b10000, 1'b1);
    expect_out("t4.go", 5'b10000, 1'b1, 4'h8, 5'b10000);
    tick();
    drive(5'b0, 5'b0, 1'b1);
    expect_out("t4.idle", 5'b0, 1'b0, 4'h0, 5'b0);

    // Input 0 starves mid-packet; input 2 must not steal the lock.
    do_reset();
    drive(5'b00001, 5'b00000, 1'b1);
    tick();
    expect_out("t5.head", 5'b00001, 1'b1, 4'hC, 5'b00001);
    tick();
    drive(5'b00100, 5'b00100, 1'b1);
    expect_out("t5.gap1", 5'b00001, 1'b0, 4'hC, 5'b0);
    tick();
    expect_out("t5.gap2", 5'b00001, 1'b0, 4'hC, 5'b0);
    tick();
    drive(5'b00101, 5'b00101, 1'b1);
    expect_out("t5.tail", 5'b00001, 1'b1, 4'hC, 5'b00001);
    tick();
    drive(5'b00100, 5'b00100, 1'b1);
    expect_out("t5.next", 5'b00100, 1'b1, 4'hA, 5'b00100);

    // Reset mid-packet on input 2 abandons it and restores the pointer.
    do_reset();
    drive(5'b00100, 5'b00000, 1'b1);
    tick();
    expect_out("t6.lock", 5'b00100, 1'b1, 4'hA, 5'b00100);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(5'b11111, 5'b11111, 1'b1);
    expect_out("t6.rst", 5'b0, 1'b0, 4'h0, 5'b0);
    tick();
    expect_out("t6.first", 5'b00001, 1'b1, 4'hC, 5'b00001);

    tick();
    armed = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
